// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared state encoding and width helper for the matrix datapath
package mat_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } mat_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mat_loader_if.sv
// rtl/mat_loader_if.sv - element stream in, packed matrices out
interface mat_loader_if #(
    parameter int Bit = 3,
    parameter int N   = 2,
    parameter int M   = 2,
    parameter int P   = 2
);
    logic [Bit-1:0]     elem_in;
    logic               elem_valid;
    logic               elem_ready;
    logic [Bit*N*M-1:0] matriz_A;
    logic [Bit*M*P-1:0] matriz_B;
    logic               mat_valid;
    logic               mat_ready;

    modport slave (
        input  elem_in, elem_valid, mat_ready,
        output elem_ready, matriz_A, matriz_B, mat_valid
    );

    modport master (
        output elem_in, elem_valid, mat_ready,
        input  elem_ready, matriz_A, matriz_B, mat_valid
    );
endinterface

// File: rtl/mat_slot_writer.sv
// rtl/mat_slot_writer.sv - packed register bus with single-slot indexed write
module mat_slot_writer #(
    parameter int W     = 3,
    parameter int SLOTS = 4,
    parameter int IW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [IW-1:0]      idx,
    input  logic [W-1:0]       din,
    output logic [W*SLOTS-1:0] bus
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus <= '0;
        end else if (we) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (idx == IW'(s)) bus[s*W +: W] <= din;
            end
        end
    end

endmodule

// File: rtl/mat_loader.sv
// rtl/mat_loader.sv - serial element stream to packed A (row-major) and B (column-major)
module mat_loader
    import mat_pkg::*;
#(
    parameter int Bit = 3,
    parameter int N   = 2,
    parameter int M   = 2,
    parameter int P   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_enable,
    input  logic       clear,
    mat_loader_if.slave bus
);

    localparam int AW = clog2_min1(N * M);
    localparam int KW = clog2_min1(M);
    localparam int JW = clog2_min1(P);
    localparam int BW = clog2_min1(M * P);

    mat_state_t         state, next_state;
    logic [AW-1:0]      idx, idx_n;
    logic [KW-1:0]      k, k_n;
    logic [JW-1:0]      j, j_n;
    logic               ready_q;
    logic               accept;
    logic               we_a, we_b;
    logic [BW-1:0]      b_slot;
    logic [Bit*N*M-1:0] bus_a;
    logic [Bit*M*P-1:0] bus_b;

    assign accept = bus.elem_valid & ready_q & clk_enable;
    assign we_a   = accept & ~clear & (state == LOAD_A);
    assign we_b   = accept & ~clear & (state == LOAD_B);
    // B arrives row-major but is stored column-major: (k,j) -> j*M+k.
    assign b_slot = BW'(int'(j) * M + int'(k));

    always_comb begin
        next_state = state;
        idx_n      = idx;
        k_n        = k;
        j_n        = j;
        case (state)
            LOAD_A: begin
                if (accept) begin
                    if (idx == AW'(N * M - 1)) begin
                        idx_n      = '0;
                        k_n        = '0;
                        j_n        = '0;
                        next_state = LOAD_B;
                    end else begin
                        idx_n = idx + AW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (j == JW'(P - 1)) begin
                        j_n = '0;
                        if (k == KW'(M - 1)) begin
                            k_n        = '0;
                            next_state = FULL;
                        end else begin
                            k_n = k + KW'(1);
                        end
                    end else begin
                        j_n = j + JW'(1);
                    end
                end
            end
            FULL: begin
                if (bus.mat_ready) begin
                    idx_n      = '0;
                    k_n        = '0;
                    j_n        = '0;
                    next_state = LOAD_A;
                end
            end
            default: next_state = LOAD_A;
        endcase
        if (clear) begin
            idx_n      = '0;
            k_n        = '0;
            j_n        = '0;
            next_state = LOAD_A;
        end
    end

    // ready is registered so it stays low through reset and drops together with mat_valid rising.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD_A;
            idx     <= '0;
            k       <= '0;
            j       <= '0;
            ready_q <= 1'b0;
        end else if (clk_enable) begin
            state   <= next_state;
            idx     <= idx_n;
            k       <= k_n;
            j       <= j_n;
            ready_q <= (next_state != FULL);
        end
    end

    mat_slot_writer #(.W(Bit), .SLOTS(N * M), .IW(AW)) u_wr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_a),
        .idx   (idx),
        .din   (bus.elem_in),
        .bus   (bus_a)
    );

    mat_slot_writer #(.W(Bit), .SLOTS(M * P), .IW(BW)) u_wr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_b),
        .idx   (b_slot),
        .din   (bus.elem_in),
        .bus   (bus_b)
    );

    assign bus.matriz_A   = bus_a;
    assign bus.matriz_B   = bus_b;
    assign bus.elem_ready = ready_q;
    assign bus.mat_valid  = (state == FULL);

endmodule

// File: tb/tb_mat_loader.sv
// tb/tb_mat_loader.sv - randomized and directed bench for mat_loader against a slot-level model
module tb_mat_loader;

    logic clk = 1'b0;
    logic rst_n, en, clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mat_loader_if #(.Bit(3), .N(2), .M(2), .P(2)) if1 ();
    mat_loader_if #(.Bit(4), .N(1), .M(3), .P(2)) if2 ();

    mat_loader #(.Bit(3), .N(2), .M(2), .P(2)) u1 (
        .clk(clk), .rst_n(rst_n), .clk_enable(en), .clear(clr), .bus(if1)
    );

    mat_loader #(.Bit(4), .N(1), .M(3), .P(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clk_enable(en), .clear(clr), .bus(if2)
    );

    // Model of u1: cnt = elements taken in the current load (8 means full).
    int         cnt;
    bit         rdy_m;
    logic [2:0] ma [4];
    logic [2:0] mb [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cnt   = 0;
        rdy_m = 1'b0;
        for (int s = 0; s < 4; s++) begin
            ma[s] = '0;
            mb[s] = '0;
        end
    endtask

    task automatic cyc(input bit v, input logic [2:0] d, input bit mr, input bit e, input bit c);
        logic [11:0] ea, eb;
        int q;
        if1.elem_valid = v;
        if1.elem_in    = d;
        if1.mat_ready  = mr;
        en             = e;
        clr            = c;
        if (e) begin
            if (c) begin
                cnt = 0;
            end else if (cnt == 8) begin
                if (mr) cnt = 0;
            end else if (v && rdy_m) begin
                if (cnt < 4) begin
                    ma[cnt] = d;
                end else begin
                    q = cnt - 4;
                    mb[(q % 2) * 2 + q / 2] = d;
                end
                cnt++;
            end
            rdy_m = (cnt != 8);
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            ea[s*3 +: 3] = ma[s];
            eb[s*3 +: 3] = mb[s];
        end
        chk("elem_ready", 32'(if1.elem_ready), 32'(rdy_m));
        chk("mat_valid",  32'(if1.mat_valid),  32'(cnt == 8));
        chk("matriz_A",   32'(if1.matriz_A),   32'(ea));
        chk("matriz_B",   32'(if1.matriz_B),   32'(eb));
    endtask

    initial begin
        logic [2:0] basic [8];
        basic = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        rst_n = 1'b0;
        en = 1'b1;
        clr = 1'b0;
        if1.elem_valid = 1'b0; if1.elem_in = '0; if1.mat_ready = 1'b0;
        if2.elem_valid = 1'b0; if2.elem_in = '0; if2.mat_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(if1.elem_ready), 32'd0);
        chk("reset_valid", 32'(if1.mat_valid), 32'd0);
        chk("reset_A", 32'(if1.matriz_A), 32'd0);
        chk("reset_B", 32'(if1.matriz_B), 32'd0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 0);

        // basic load
        for (int i = 0; i < 8; i++) cyc(1, basic[i], 0, 1, 0);
        chk("basic_A", 32'(if1.matriz_A), 32'h8D1);
        chk("basic_B", 32'(if1.matriz_B), 32'h1BD);

        // backpressure, then take
        repeat (10) cyc(1, 3'd7, 0, 1, 0);
        chk("hold_A", 32'(if1.matriz_A), 32'h8D1);
        chk("hold_B", 32'(if1.matriz_B), 32'h1BD);
        cyc(1, 3'd7, 1, 1, 0);
        cyc(1, 3'd7, 0, 1, 0);
        chk("after_take_slot0", 32'(if1.matriz_A[2:0]), 32'd7);

        // clk_enable gating after the 2nd element of A
        cyc(1, 3'd2, 0, 1, 0);
        repeat (3) cyc(1, 3'd5, 0, 0, 0);
        cyc(1, 3'd6, 0, 1, 0);
        chk("gate_slot2", 32'(if1.matriz_A[8:6]), 32'd6);
        for (int i = 0; i < 5; i++) cyc(1, 3'($urandom), 0, 1, 0);
        cyc(0, 0, 1, 1, 0);

        // clear on the 6th element
        for (int i = 0; i < 5; i++) cyc(1, 3'($urandom), 0, 1, 0);
        cyc(1, 3'd3, 0, 1, 1);
        for (int i = 0; i < 8; i++) cyc(1, 3'($urandom), 0, 1, 0);
        cyc(0, 0, 1, 1, 0);

        // async reset mid LOAD_B
        for (int i = 0; i < 5; i++) cyc(1, 3'($urandom), 0, 1, 0);
        if1.elem_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_A", 32'(if1.matriz_A), 32'd0);
        chk("arst_B", 32'(if1.matriz_B), 32'd0);
        chk("arst_valid", 32'(if1.mat_valid), 32'd0);
        chk("arst_ready", 32'(if1.elem_ready), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom % 4) != 0, 3'($urandom), ($urandom % 3) == 0,
                ($urandom % 8) != 0, ($urandom % 50) == 0);
        end

        // non-square instance: Bit=4, N=1, M=3, P=2
        for (int i = 1; i <= 9; i++) begin
            if2.elem_valid = 1'b1;
            if2.elem_in    = 4'(i);
            cyc(0, 0, 0, 1, 0);
            chk("ns_valid", 32'(if2.mat_valid), 32'(i == 9));
            chk("ns_ready", 32'(if2.elem_ready), 32'(i != 9));
        end
        if2.elem_valid = 1'b0;
        chk("ns_A", 32'(if2.matriz_A), 32'h321);
        chk("ns_B", 32'(if2.matriz_B), 32'h975864);
        if2.mat_ready = 1'b1;
        cyc(0, 0, 0, 1, 0);
        if2.mat_ready = 1'b0;
        chk("ns_take_valid", 32'(if2.mat_valid), 32'd0);
        chk("ns_take_ready", 32'(if2.elem_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_loader.md
Name: mat_loader

Overview:
- Serial-to-packed front end for the matrix multiplier datapath.
- Accepts a stream of Bit-wide elements over a valid/ready handshake: all of matrix A row-major, then all of matrix B row-major.
- Assembles them into the flat packed buses the multiplier consumes, with B stored column-major (transposed on the fly).
- Presents both matrices with a valid/ready output handshake and holds them stable until taken.

Parameters:
- Bit, 3, element width in bits.
- N, 2, rows of A.
- M, 2, columns of A and rows of B.
- P, 2, columns of B.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_enable  in  1  global advance enable; when low, all registers hold.
- clear  in  1  synchronous abort: discard the partial or complete load and return to LOAD_A.
- elem_in  in  Bit  element data.
- elem_valid  in  1  elem_in is valid.
- elem_ready  out  1  block can accept an element.
- matriz_A  out  Bit*N*M  packed A; element (i,k) at slot i*M+k.
- matriz_B  out  Bit*M*P  packed B; element (k,j) at slot j*M+k.
- mat_valid  out  1  both matrices complete and stable.
- mat_ready  in  1  consumer takes the matrices.

Behaviour:
- Slot s occupies bits [(s+1)*Bit-1 -: Bit].
- Reset (rst_n low, asynchronous):
  - state=LOAD_A; counters idx and col/row = 0.
  - matriz_A=0, matriz_B=0, mat_valid=0.
  - elem_ready=0 while rst_n is low; 1 from the first clock after release.
- All transitions occur only on posedge clk with clk_enable=1. When clk_enable=0, state, counters, outputs and the handshake accept are frozen and no element is consumed.
- Accept = elem_valid & elem_ready & clk_enable.
- LOAD_A:
  - elem_ready=1.
  - On accept: write elem_in to matriz_A slot idx, idx++.
  - On accept of element N*M-1: idx=0, k=0, j=0, go to LOAD_B.
- LOAD_B:
  - elem_ready=1.
  - Input order is row-major (k outer, j inner).
  - On accept: write elem_in to matriz_B slot j*M+k; j++.
  - When j wraps at P: j=0, k++.
  - On accept of the last element (k=M-1, j=P-1): go to FULL and set mat_valid=1 in the same edge.
  - mat_valid is therefore high in the cycle after the final accept (latency 1).
- FULL:
  - elem_ready=0; mat_valid=1; matriz_A and matriz_B held constant.
  - On mat_ready & clk_enable: mat_valid=0, go to LOAD_A, counters=0.
  - The packed buses keep their old contents until overwritten slot by slot.
  - elem_ready returns to 1 in the cycle after the take.
- clear: highest priority, wins over accept and over mat_ready in the same cycle.
  - Next state LOAD_A, counters=0, mat_valid=0.
  - Buses are not zeroed.
- elem_valid in FULL is ignored; no element is lost because elem_ready=0.
- Reset asserted mid-load: immediate return to reset values; the partial matrix is discarded.
- Degenerate sizes N, M, P = 1 must work: a single-slot phase completes on its first accept.
- Counter widths: clog2 of the largest count, minimum 1 bit. No arithmetic on element data.

Decomposition:
- Shared package (mat_pkg): state encoding localparams (LOAD_A, LOAD_B, FULL) and a clog2 constant function.
- Both are reused by the multiplier control and a future result unloader.
- One sub-module, mat_slot_writer, is natural: a packed-bus register with indexed single-slot write enable, instantiated once for A and once for B.
- The rest (FSM, counters, B index mapping) lives in mat_loader.

Test Plan:
- Basic load, Bit=3, N=M=P=2: stream 1,2,3,4 then 5,6,7,0 with elem_valid held high.
  - Required: matriz_A=12'h8D1, matriz_B=12'h1BD.
  - mat_valid rises one cycle after the 8th accept; elem_ready=0 while mat_valid=1.
- Backpressure: keep mat_ready=0 for 10 cycles while elem_valid=1 with value 7.
  - Required: buses unchanged and no accept.
  - Then mat_ready=1 for one cycle: mat_valid=0 next cycle, elem_ready=1 the cycle after, and the next element lands in slot 0 of A.
- clk_enable gating: drop clk_enable for 3 cycles after the 2nd element of A while elem_valid=1.
  - Required: idx frozen at 2, no write; resuming writes the next value to slot 2.
- clear priority: assert clear together with elem_valid on the 6th element.
  - Required: that element is not written and the state returns to LOAD_A.
  - A fresh 8-element stream then yields correct buses.
- Async reset mid-LOAD_B: pulse rst_n low between clock edges.
  - Required: matriz_A=0, matriz_B=0, mat_valid=0 immediately, without waiting for a clock edge.
  - elem_ready=1 one clock after release.
- Non-square, Bit=4, N=1, M=3, P=2: A=1,2,3; B row-major 4,5,6,7,8,9.
  - Required: matriz_A=12'h321, matriz_B=24'h975864.
